// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 device-transmitter types, constants and frame helpers
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUS = 3'd1,
    ST_HIGH     = 3'd2,
    ST_LOW      = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bit 0 leaves first: start 0, data LSB-first, odd parity, stop 1.
  function automatic logic [PS2_FRAME_BITS-1:0] build_frame(input logic [7:0] d);
    return {1'b1, odd_parity(d), d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_device_tx_if.sv
// rtl/ps2_device_tx_if.sv - byte handshake between a scan-code source and the PS/2 transmitter
interface ps2_device_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_abort;
  logic       busy;

  modport master (output tx_data, tx_valid, input tx_ready, tx_done, tx_abort, busy);
  modport slave  (input tx_data, tx_valid, output tx_ready, tx_done, tx_abort, busy);
endinterface

// File: rtl/ps2_sync2.sv
// rtl/ps2_sync2.sv - two-flop synchroniser for an idle-high open-drain pin
module ps2_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/ps2_device_tx.sv
// rtl/ps2_device_tx.sv - PS/2 device-side transmitter: generates PS2_CLK and sends 11-bit frames
module ps2_device_tx #(
  parameter int CLK_HALF_CYCLES = 2000,
  parameter int DATA_SETUP      = 1000,
  parameter int IDLE_GAP        = 2500,
  parameter int INHIBIT_GRACE   = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  ps2_device_tx_if.slave     tx,
  input  logic               ps2_clk_in,
  input  logic               ps2_dat_in,
  output logic               ps2_clk_drive_low,
  output logic               ps2_dat_drive_low,
  output logic               host_rts
);
  import ps2_pkg::*;

  localparam int MAX_A = (IDLE_GAP > CLK_HALF_CYCLES) ? IDLE_GAP : CLK_HALF_CYCLES;
  localparam int CNT_W = $clog2(MAX_A + 1) + 1;
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic                      w_clk;
  logic                      w_dat;
  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [3:0]                r_bit_idx;
  logic [PS2_FRAME_BITS-1:0] r_shift;
  logic                      r_clk_drv;
  logic                      r_dat_drv;
  logic                      r_tx_ready;
  logic                      r_tx_done;
  logic                      r_tx_abort;
  logic                      r_busy;
  logic                      r_host_rts;

  ps2_sync2 u_sync_clk (.i_clk(CLOCK_50), .i_rst_n(reset_n), .i_d(ps2_clk_in), .o_q(w_clk));
  ps2_sync2 u_sync_dat (.i_clk(CLOCK_50), .i_rst_n(reset_n), .i_d(ps2_dat_in), .o_q(w_dat));

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_clk_drv  <= 1'b0;
      r_dat_drv  <= 1'b0;
      r_tx_ready <= 1'b1;
      r_tx_done  <= 1'b0;
      r_tx_abort <= 1'b0;
      r_busy     <= 1'b0;
      r_host_rts <= 1'b0;
    end else begin
      r_tx_done  <= 1'b0;
      r_tx_abort <= 1'b0;
      r_host_rts <= ((r_state == ST_IDLE) || (r_state == ST_WAIT_BUS)) && w_clk && !w_dat;

      case (r_state)
        ST_IDLE: begin
          if (tx.tx_valid && r_tx_ready) begin
            r_shift    <= build_frame(tx.tx_data);
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_WAIT_BUS;
          end
        end

        // A host RTS holds dat low, so it also keeps this count from completing.
        ST_WAIT_BUS: begin
          if (w_clk && w_dat) begin
            if (r_cnt == CNT_W'(IDLE_GAP - 1)) begin
              r_cnt     <= '0;
              r_bit_idx <= '0;
              r_state   <= ST_HIGH;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end

        // The grace window hides our own released clock still low in the synchroniser.
        ST_HIGH: begin
          if ((r_cnt >= CNT_W'(INHIBIT_GRACE)) && !w_clk) begin
            r_clk_drv <= 1'b0;
            r_dat_drv <= 1'b0;
            r_cnt     <= '0;
            if (r_bit_idx == LAST_BIT) begin
              r_tx_done <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_tx_abort <= 1'b1;
              r_state    <= ST_WAIT_BUS;
            end
          end else begin
            if (r_cnt == CNT_W'(DATA_SETUP)) begin
              r_dat_drv <= ~r_shift[r_bit_idx];
            end
            if (r_cnt == CNT_W'(CLK_HALF_CYCLES - 1)) begin
              r_cnt     <= '0;
              r_clk_drv <= 1'b1;
              r_state   <= ST_LOW;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        ST_LOW: begin
          if (r_cnt == CNT_W'(CLK_HALF_CYCLES - 1)) begin
            r_cnt     <= '0;
            r_clk_drv <= 1'b0;
            if (r_bit_idx == LAST_BIT) begin
              r_tx_done <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
              r_state   <= ST_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          r_clk_drv  <= 1'b0;
          r_dat_drv  <= 1'b0;
          r_busy     <= 1'b0;
          r_tx_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx.tx_ready        = r_tx_ready;
  assign tx.tx_done         = r_tx_done;
  assign tx.tx_abort        = r_tx_abort;
  assign tx.busy            = r_busy;
  assign ps2_clk_drive_low  = r_clk_drv;
  assign ps2_dat_drive_low  = r_dat_drv;
  assign host_rts           = r_host_rts;
endmodule

// File: tb/tb_ps2_device_tx.sv
// tb/tb_ps2_device_tx.sv - self-checking bench for ps2_device_tx with a PS/2 host model
module tb_ps2_device_tx;
  localparam int H   = 20;
  localparam int DS  = 10;
  localparam int GAP = 25;
  localparam int GR  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic host_clk_pull = 1'b0;
  logic host_dat_pull = 1'b0;
  logic clk_drv, dat_drv, host_rts;
  logic bus_clk, bus_dat;

  int checks = 0;
  int failures = 0;

  ps2_device_tx_if txi ();

  assign bus_clk = !(clk_drv || host_clk_pull);
  assign bus_dat = !(dat_drv || host_dat_pull);

  ps2_device_tx #(.CLK_HALF_CYCLES(H), .DATA_SETUP(DS), .IDLE_GAP(GAP), .INHIBIT_GRACE(GR)) dut (
    .CLOCK_50          (clk),
    .reset_n           (reset_n),
    .tx                (txi),
    .ps2_clk_in        (bus_clk),
    .ps2_dat_in        (bus_dat),
    .ps2_clk_drive_low (clk_drv),
    .ps2_dat_drive_low (dat_drv),
    .host_rts          (host_rts)
  );

  always #10 clk = ~clk;

  // Host model: samples dat on every device-generated falling clock edge.
  int cyc = 0, rise_cnt = 0, rel_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int start_cyc = 0, last_done = 0;
  logic await_gap = 1'b0;
  logic prev_clk = 1'b0;
  logic bitq[$];
  logic [10:0] frame_q[$];
  int nbits_q[$];
  int lat_q[$];
  int gap_q[$];

  always @(negedge clk) begin
    logic [10:0] w;
    cyc++;
    if (!reset_n) begin
      bitq.delete();
      prev_clk = 1'b0;
    end else begin
      if (clk_drv && !prev_clk) begin
        if (bitq.size() == 0) start_cyc = cyc;
        bitq.push_back(bus_dat);
        rise_cnt++;
        if (await_gap) begin
          gap_q.push_back(cyc - last_done);
          await_gap = 1'b0;
        end
      end
      if (!clk_drv && prev_clk) rel_cnt++;
      if (txi.tx_done) begin
        w = '0;
        for (int i = 0; i < bitq.size() && i < 11; i++) w[i] = bitq[i];
        frame_q.push_back(w);
        nbits_q.push_back(bitq.size());
        lat_q.push_back(cyc - start_cyc);
        bitq.delete();
        done_cnt++;
        last_done = cyc;
        await_gap = 1'b1;
      end
      if (txi.tx_abort) begin
        abort_cnt++;
        bitq.delete();
      end
      prev_clk = clk_drv;
    end
  end

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!txi.tx_ready && n < 3000) begin tick(1); n++; end
    chk("send_ready_timeout", 32'(n < 3000), 1);
    txi.tx_data  = b;
    txi.tx_valid = 1'b1;
    tick(1);
    txi.tx_valid = 1'b0;
  endtask

  int fi = 0;

  task automatic check_frame(input string tag, input logic [10:0] exp);
    int n = 0;
    while (frame_q.size() <= fi && n < 3000) begin tick(1); n++; end
    chk({tag, "_timeout"}, 32'(n < 3000), 1);
    if (frame_q.size() > fi) begin
      chk({tag, "_nbits"}, nbits_q[fi], 11);
      chk({tag, "_bits"}, 32'(frame_q[fi]), 32'(exp));
      chk({tag, "_latency"}, lat_q[fi], (2 * 11 - 1) * H);
      fi++;
    end
  endtask

  task automatic wait_rel(input int base, input int target);
    int n = 0;
    while ((rel_cnt - base) < target && n < 3000) begin tick(1); n++; end
    chk("wait_rel_timeout", 32'(n < 3000), 1);
  endtask

  initial begin
    logic [7:0] rb;
    int d0, a0, r0, g0, n;
    txi.tx_data  = 8'h00;
    txi.tx_valid = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    chk("rst_tx_ready", txi.tx_ready, 1);
    chk("rst_busy", txi.busy, 0);
    chk("rst_drv", {30'd0, clk_drv, dat_drv}, 0);
    chk("rst_done_abort_rts", {29'd0, txi.tx_done, txi.tx_abort, host_rts}, 0);

    // 1: single 'A' make code
    d0 = done_cnt;
    send_byte(8'h1C);
    chk("t1_ready_drop", txi.tx_ready, 0);
    chk("t1_busy", txi.busy, 1);
    check_frame("t1", 11'h438);
    tick(3);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_idle", {30'd0, txi.busy, txi.tx_ready}, 1);

    // 2: break code back-to-back
    send_byte(8'hF0);
    send_byte(8'h1C);
    g0 = gap_q.size();
    check_frame("t2a", 11'h7E0);
    check_frame("t2b", 11'h438);
    chk("t2_gap", 32'(gap_q.size() > g0 && gap_q[g0] >= GAP + H), 1);

    // randomized bytes against the host model
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb);
      check_frame("rand", model_frame(rb));
    end

    // 3: host inhibit during bit 4
    tick(5);
    a0 = abort_cnt; d0 = done_cnt;
    r0 = rel_cnt;
    send_byte(8'h1C);
    wait_rel(r0, 4);
    tick(6);
    host_clk_pull = 1'b1;
    n = 0;
    while (abort_cnt == a0 && !txi.tx_abort && n < 3) begin tick(1); n++; end
    chk("t3_abort_pulse", txi.tx_abort, 1);
    chk("t3_released", {30'd0, clk_drv, dat_drv}, 0);
    tick(5000);
    host_clk_pull = 1'b0;
    check_frame("t3_resend", 11'h438);
    chk("t3_abort_once", abort_cnt - a0, 1);
    chk("t3_done_once", done_cnt - d0, 1);

    // 4: host inhibit during the stop bit
    tick(5);
    a0 = abort_cnt; d0 = done_cnt;
    r0 = rel_cnt;
    send_byte(8'h5A);
    wait_rel(r0, 10);
    tick(8);
    host_clk_pull = 1'b1;
    tick(6);
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_no_abort", abort_cnt - a0, 0);
    tick(50);
    host_clk_pull = 1'b0;
    r0 = rise_cnt;
    tick(300);
    chk("t4_no_retx", rise_cnt - r0, 0);
    chk("t4_idle", {30'd0, txi.busy, txi.tx_ready}, 1);
    fi = frame_q.size();

    // 5: host RTS blocks the frame until dat is released
    host_dat_pull = 1'b1;
    tick(5);
    chk("t5_rts", host_rts, 1);
    r0 = rise_cnt;
    send_byte(8'h29);
    tick(200);
    chk("t5_no_clk", rise_cnt - r0, 0);
    chk("t5_rts_held", host_rts, 1);
    host_dat_pull = 1'b0;
    check_frame("t5", model_frame(8'h29));
    chk("t5_parity0", 32'(frame_q[fi-1][9]), 0);

    // 6: reset mid-frame during bit 6
    tick(5);
    d0 = done_cnt;
    r0 = rel_cnt;
    send_byte(8'h33);
    wait_rel(r0, 6);
    n = 0;
    while (!clk_drv && n < 100) begin tick(1); n++; end
    chk("t6_pre_clk_drv", clk_drv, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_async_release", {30'd0, clk_drv, dat_drv}, 0);
    tick(2);
    reset_n = 1'b1;
    tick(200);
    chk("t6_ready", txi.tx_ready, 1);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_not_busy", txi.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
